// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned a_size);
    return 32'(1) << a_size;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous registered read, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned D_SIZE = 8,
  parameter int unsigned A_SIZE = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [A_SIZE-1:0] waddr,
  input  logic [D_SIZE-1:0] wdata,
  input  logic              re,
  input  logic [A_SIZE-1:0] raddr,
  output logic [D_SIZE-1:0] rdata
);

  localparam int unsigned DEPTH = fifo_depth(A_SIZE);

  logic [D_SIZE-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy,
// almost-full/empty thresholds and sticky overflow/underflow flags.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int unsigned D_SIZE   = 8,
  parameter int unsigned A_SIZE   = 4,
  parameter int unsigned FWFT     = FIFO_STD,
  parameter int unsigned AF_LEVEL = 14,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [D_SIZE-1:0] wdata,
  input  logic              ren,
  output logic [D_SIZE-1:0] rdata,
  output logic              rvalid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [A_SIZE:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned DEPTH   = fifo_depth(A_SIZE);
  localparam int unsigned CW      = A_SIZE + 1;
  localparam bit          IS_FWFT = (FWFT == FIFO_FWFT);

  logic [A_SIZE:0]   wr_ptr;
  logic [A_SIZE:0]   rd_ptr;
  logic [A_SIZE:0]   count_nx;
  logic [A_SIZE:0]   mem_cnt_c;
  logic              wr_acc_c;
  logic              rd_acc_c;
  logic              fetch_c;
  logic              out_valid;
  logic              out_valid_nx;
  logic              q_live;
  logic [D_SIZE-1:0] ram_q;

  // Acceptance, RAM fetch and next occupancy. In FWFT the RAM read register
  // doubles as the output stage: refill it whenever it is idle or being popped.
  always_comb begin
    wr_acc_c     = wen && !full;
    rd_acc_c     = ren && !empty;
    mem_cnt_c    = wr_ptr - rd_ptr;
    fetch_c      = rd_acc_c;
    out_valid_nx = 1'b0;
    count_nx     = count;
    if (IS_FWFT) begin
      fetch_c      = (!out_valid || rd_acc_c) && (mem_cnt_c != '0);
      out_valid_nx = fetch_c || (out_valid && !rd_acc_c);
    end
    case ({wr_acc_c, rd_acc_c})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      q_live       <= 1'b0;
      rvalid       <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr <= wr_ptr + CW'(1);
      if (fetch_c) begin
        rd_ptr <= rd_ptr + CW'(1);
        q_live <= 1'b1;
      end
      count        <= count_nx;
      out_valid    <= out_valid_nx;
      rvalid       <= IS_FWFT ? out_valid_nx : rd_acc_c;
      empty        <= IS_FWFT ? !out_valid_nx : (count_nx == '0);
      full         <= (count_nx == CW'(DEPTH));
      almost_full  <= (count_nx >= CW'(AF_LEVEL));
      almost_empty <= (count_nx <= CW'(AE_LEVEL));
      overflow     <= (wen && full) || (overflow && !err_clr);
      underflow    <= (ren && empty) || (underflow && !err_clr);
    end
  end

  fifo_ram #(
    .D_SIZE (D_SIZE),
    .A_SIZE (A_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc_c),
    .waddr (wr_ptr[A_SIZE-1:0]),
    .wdata (wdata),
    .re    (fetch_c),
    .raddr (rd_ptr[A_SIZE-1:0]),
    .rdata (ram_q)
  );

  // The RAM read register has no reset; mask it until a word has actually been read.
  assign rdata = q_live ? ram_q : '0;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench driving a standard-mode and an FWFT-mode fifo_sync with identical stimulus.
module tb_fifo_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       wen;
  logic       ren;
  logic       err_clr;
  logic [7:0] wdata;

  logic [7:0] rdata  [2];
  logic       rvalid [2];
  logic       empty  [2];
  logic       full   [2];
  logic       afull  [2];
  logic       aempty [2];
  logic       ovf    [2];
  logic       unf    [2];
  logic [4:0] count  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync #(.D_SIZE(8), .A_SIZE(4), .FWFT(0), .AF_LEVEL(14), .AE_LEVEL(2)) u_std (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata[0]), .rvalid(rvalid[0]), .empty(empty[0]), .full(full[0]),
    .almost_full(afull[0]), .almost_empty(aempty[0]), .count(count[0]),
    .overflow(ovf[0]), .underflow(unf[0]), .err_clr(err_clr)
  );

  fifo_sync #(.D_SIZE(8), .A_SIZE(4), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_fwft (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata[1]), .rvalid(rvalid[1]), .empty(empty[1]), .full(full[1]),
    .almost_full(afull[1]), .almost_empty(aempty[1]), .count(count[1]),
    .overflow(ovf[1]), .underflow(unf[1]), .err_clr(err_clr)
  );

  task automatic tick(input logic w, input logic [7:0] wd, input logic r, input logic c);
    wen = w; wdata = wd; ren = r; err_clr = c;
    @(posedge clk); #1;
    wen = 1'b0; ren = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; wen = 1'b0; ren = 1'b0; err_clr = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({empty[m], full[m], aempty[m], afull[m], ovf[m], unf[m], rvalid[m]} !== 7'b1010000 ||
          count[m] !== 5'd0 || rdata[m] !== 8'h00) begin
        errors++;
        $display("FAIL reset m%0d flags %b count %0d rdata %h, want flags 1010000 count 0 rdata 00",
                 m, {empty[m], full[m], aempty[m], afull[m], ovf[m], unf[m], rvalid[m]}, count[m], rdata[m]);
      end
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 8'(i), 1'b0, 1'b0);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (count[m] !== 5'(i + 1) || full[m] !== (i == 15) || afull[m] !== (i >= 13) || aempty[m] !== (i <= 1)) begin
          errors++;
          $display("FAIL fill m%0d i%0d count %0d full %b afull %b aempty %b, want count %0d full %b afull %b aempty %b",
                   m, i, count[m], full[m], afull[m], aempty[m], i + 1, i == 15, i >= 13, i <= 1);
        end
      end
      checks++;
      if (empty[0] !== 1'b0 || empty[1] !== (i == 0)) begin
        errors++;
        $display("FAIL fill_empty i%0d std %b fwft %b, want std 0 fwft %b", i, empty[0], empty[1], i == 0);
      end
    end
    tick(1'b1, 8'hFF, 1'b0, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (count[m] !== 5'd16 || full[m] !== 1'b1 || ovf[m] !== 1'b1) begin
        errors++;
        $display("FAIL overflow m%0d count %0d full %b ovf %b, want 16 1 1", m, count[m], full[m], ovf[m]);
      end
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rdata[1] !== 8'(i) || rvalid[1] !== 1'b1) begin
        errors++;
        $display("FAIL drain_fwft i%0d rdata %h rvalid %b, want %h 1", i, rdata[1], rvalid[1], 8'(i));
      end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (rdata[0] !== 8'(i) || rvalid[0] !== 1'b1) begin
        errors++;
        $display("FAIL drain_std i%0d rdata %h rvalid %b, want %h 1", i, rdata[0], rvalid[0], 8'(i));
      end
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (count[m] !== 5'(15 - i) || aempty[m] !== (i >= 13)) begin
          errors++;
          $display("FAIL drain_count m%0d i%0d count %0d aempty %b, want %0d %b", m, i, count[m], aempty[m], 15 - i, i >= 13);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (empty[m] !== 1'b1) begin
        errors++;
        $display("FAIL drain_empty m%0d empty %b, want 1", m, empty[m]);
      end
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (unf[m] !== 1'b1 || rdata[m] !== 8'h0F || rvalid[m] !== 1'b0 || count[m] !== 5'd0) begin
        errors++;
        $display("FAIL underflow m%0d unf %b rdata %h rvalid %b count %0d, want 1 0f 0 0", m, unf[m], rdata[m], rvalid[m], count[m]);
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ovf[m] !== 1'b0 || unf[m] !== 1'b0) begin
        errors++;
        $display("FAIL err_clr m%0d ovf %b unf %b, want 0 0", m, ovf[m], unf[m]);
      end
    end
  endtask

  task automatic test_wrap;
    int nw = 0;
    int nr = 0;
    int occ = 0;
    for (int cyc = 0; cyc < 300 && nr < 40; cyc++) begin
      bit w;
      bit r;
      w = (nw < 40) && (occ < 10) && (cyc % 3 != 2);
      r = (occ >= 4 && (cyc % 2 == 0 || occ == 10)) || (nw == 40 && occ > 0);
      if (r) begin
        checks++;
        if (rdata[1] !== 8'(nr) || rvalid[1] !== 1'b1) begin
          errors++;
          $display("FAIL wrap_fwft n%0d rdata %h rvalid %b, want %h 1", nr, rdata[1], rvalid[1], 8'(nr));
        end
      end
      tick(w, 8'(nw), r, 1'b0);
      if (r) begin
        checks++;
        if (rdata[0] !== 8'(nr) || rvalid[0] !== 1'b1) begin
          errors++;
          $display("FAIL wrap_std n%0d rdata %h rvalid %b, want %h 1", nr, rdata[0], rvalid[0], 8'(nr));
        end
      end
      nw += int'(w);
      nr += int'(r);
      occ = occ + int'(w) - int'(r);
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (count[m] !== 5'(occ)) begin
          errors++;
          $display("FAIL wrap_count m%0d count %0d, want %0d", m, count[m], occ);
        end
      end
    end
    checks++;
    if (nr != 40) begin
      errors++;
      $display("FAIL wrap_timeout reads %0d, want 40", nr);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (ovf[m] !== 1'b0 || unf[m] !== 1'b0 || empty[m] !== 1'b1) begin
        errors++;
        $display("FAIL wrap_flags m%0d ovf %b unf %b empty %b, want 0 0 1", m, ovf[m], unf[m], empty[m]);
      end
    end
  endtask

  task automatic test_simultaneous;
    int nw = 0;
    int nr = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 8'(8'h50 + nw), 1'b0, 1'b0);
      nw++;
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rdata[1] !== 8'(8'h50 + nr)) begin
        errors++;
        $display("FAIL simul_fwft k%0d rdata %h, want %h", k, rdata[1], 8'(8'h50 + nr));
      end
      tick(1'b1, 8'(8'h50 + nw), 1'b1, 1'b0);
      checks++;
      if (rdata[0] !== 8'(8'h50 + nr) || count[0] !== 5'd5 || count[1] !== 5'd5) begin
        errors++;
        $display("FAIL simul_std k%0d rdata %h count %0d/%0d, want %h 5/5", k, rdata[0], count[0], count[1], 8'(8'h50 + nr));
      end
      nw++;
      nr++;
    end
    for (int i = 0; i < 11; i++) begin
      tick(1'b1, 8'(8'h50 + nw), 1'b0, 1'b0);
      nw++;
    end
    checks++;
    if (rdata[1] !== 8'(8'h50 + nr) || full[0] !== 1'b1 || full[1] !== 1'b1) begin
      errors++;
      $display("FAIL full_head rdata %h full %b/%b, want %h 1/1", rdata[1], full[0], full[1], 8'(8'h50 + nr));
    end
    tick(1'b1, 8'hEE, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (count[m] !== 5'd15 || ovf[m] !== 1'b1 || full[m] !== 1'b0) begin
        errors++;
        $display("FAIL full_rw m%0d count %0d ovf %b full %b, want 15 1 0", m, count[m], ovf[m], full[m]);
      end
    end
    checks++;
    if (rdata[0] !== 8'(8'h50 + nr)) begin
      errors++;
      $display("FAIL full_rw_std rdata %h, want %h", rdata[0], 8'(8'h50 + nr));
    end
    nr++;
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (rdata[0] !== 8'(8'h50 + nr)) begin
        errors++;
        $display("FAIL full_drain i%0d rdata %h, want %h", i, rdata[0], 8'(8'h50 + nr));
      end
      nr++;
    end
    tick(1'b1, 8'h77, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (count[m] !== 5'd1 || unf[m] !== 1'b1 || ovf[m] !== 1'b0) begin
        errors++;
        $display("FAIL empty_rw m%0d count %0d unf %b ovf %b, want 1 1 0", m, count[m], unf[m], ovf[m]);
      end
    end
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (rdata[1] !== 8'h77 || rvalid[1] !== 1'b1 || unf[1] !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw_fwft rdata %h rvalid %b unf %b, want 77 1 0", rdata[1], rvalid[1], unf[1]);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rdata[0] !== 8'h77 || count[0] !== 5'd0 || count[1] !== 5'd0) begin
      errors++;
      $display("FAIL empty_rw_pop rdata %h count %0d/%0d, want 77 0/0", rdata[0], count[0], count[1]);
    end
  endtask

  task automatic test_midreset;
    for (int i = 0; i < 9; i++) tick(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    tick(1'b1, 8'h00, 1'b1, 1'b0);
    checks++;
    if (count[0] !== 5'd9 || count[1] !== 5'd9 || ovf[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre count %0d/%0d ovf %b, want 9/9 0", count[0], count[1], ovf[0]);
    end
    rst = 1'b1;
    tick(1'b1, 8'h99, 1'b1, 1'b0);
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({empty[m], full[m], aempty[m], afull[m], ovf[m], unf[m], rvalid[m]} !== 7'b1010000 ||
          count[m] !== 5'd0 || rdata[m] !== 8'h00) begin
        errors++;
        $display("FAIL mid_reset m%0d flags %b count %0d rdata %h, want flags 1010000 count 0 rdata 00",
                 m, {empty[m], full[m], aempty[m], afull[m], ovf[m], unf[m], rvalid[m]}, count[m], rdata[m]);
      end
    end
    tick(1'b1, 8'hA5, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (rdata[1] !== 8'hA5 || rvalid[1] !== 1'b1) begin
      errors++;
      $display("FAIL mid_fwft rdata %h rvalid %b, want a5 1", rdata[1], rvalid[1]);
    end
    tick(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (rdata[0] !== 8'hA5 || rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_std rdata %h rvalid %b, want a5 1", rdata[0], rvalid[0]);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (count[m] !== 5'd0 || empty[m] !== 1'b1) begin
        errors++;
        $display("FAIL mid_end m%0d count %0d empty %b, want 0 1", m, count[m], empty[m]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
